// File: rtl/sec_min_counter.sv
// Seconds/minutes digit counter with RUN/SET modes, edge-detected adjust buttons
// and a validated preset load. One instance per digit pair; carry feeds the next.
module sec_min_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [0:5] load_val,
    output logic [0:5] count,
    output logic       carry,
    output logic       at_max,
    output logic       load_err,
    output logic       in_set
);

    localparam logic [5:0] LP_MAX = 6'(MAX);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_count;
    logic [5:0] w_count_nxt;
    logic       r_carry;
    logic       w_carry_nxt;
    logic       r_load_err;
    logic       w_load_err_nxt;
    logic       r_inc_d;
    logic       r_dec_d;
    logic       w_inc_rise;
    logic       w_dec_rise;
    logic       w_load_ok;
    logic       w_at_max;
    logic [5:0] w_load_val;

    assign w_load_val = load_val;
    assign w_inc_rise = inc && !r_inc_d;
    assign w_dec_rise = dec && !r_dec_d;
    assign w_load_ok  = load && (w_load_val <= LP_MAX);
    assign w_at_max   = (r_count == LP_MAX);

    // All events are judged against the state held before the edge, so a tick
    // arriving with the RUN->SET request still counts.
    always_comb begin
        w_state_nxt    = set_mode ? ST_SET : ST_RUN;
        w_count_nxt    = r_count;
        w_carry_nxt    = 1'b0;
        w_load_err_nxt = load && !w_load_ok;

        if (w_load_ok) begin
            w_count_nxt = w_load_val;
        end else if (r_state == ST_RUN) begin
            if (tick) begin
                if (w_at_max) begin
                    w_count_nxt = 6'd0;
                    w_carry_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + 6'd1;
                end
            end
        end else begin
            if (w_inc_rise && !w_dec_rise) begin
                w_count_nxt = w_at_max ? 6'd0 : r_count + 6'd1;
            end else if (w_dec_rise && !w_inc_rise) begin
                w_count_nxt = (r_count == 6'd0) ? LP_MAX : r_count - 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_count    <= 6'd0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
            r_inc_d    <= 1'b0;
            r_dec_d    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_carry    <= w_carry_nxt;
            r_load_err <= w_load_err_nxt;
            r_inc_d    <= inc;
            r_dec_d    <= dec;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign at_max   = w_at_max;
    assign load_err = r_load_err;
    assign in_set   = (r_state == ST_SET);

endmodule

// File: tb/tb_sec_min_counter.sv
// Bench for sec_min_counter: directed scenarios plus random traffic, all checked
// against an integer-arithmetic reference model of the counter's behaviour.
module tb_sec_min_counter;

    localparam int MAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       load = 1'b0;
    logic [0:5] load_val = '0;
    logic [0:5] count;
    logic       carry;
    logic       at_max;
    logic       load_err;
    logic       in_set;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_count = 0;
    bit m_set = 0;
    bit m_carry = 0;
    bit m_err = 0;
    bit m_inc_prev = 0;
    bit m_dec_prev = 0;

    int carries;

    sec_min_counter #(.MAX(MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .set_mode (set_mode),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .at_max   (at_max),
        .load_err (load_err),
        .in_set   (in_set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ir, dr;
        int lv, delta;
        lv = int'(load_val);
        if (rst) begin
            m_count = 0; m_set = 0; m_carry = 0; m_err = 0;
            m_inc_prev = 0; m_dec_prev = 0;
            return;
        end
        ir = inc && !m_inc_prev;
        dr = dec && !m_dec_prev;
        m_carry = 0;
        m_err = 0;
        if (load && lv <= MAX) begin
            m_count = lv;
        end else begin
            if (load) m_err = 1;
            if (!m_set && tick) begin
                if (m_count == MAX) m_carry = 1;
                m_count = (m_count + 1) % (MAX + 1);
            end else if (m_set) begin
                delta = int'(ir) - int'(dr);
                m_count = (m_count + delta + MAX + 1) % (MAX + 1);
            end
        end
        m_set = set_mode;
        m_inc_prev = inc;
        m_dec_prev = dec;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("count", int'(count), m_count);
        chk("carry", int'(carry), int'(m_carry));
        chk("load_err", int'(load_err), int'(m_err));
        chk("in_set", int'(in_set), int'(m_set));
        chk("at_max", int'(at_max), int'(m_count == MAX));
        if (carry) carries++;
    endtask

    task automatic clear_in();
        tick = 0; inc = 0; dec = 0; load = 0; rst = 0;
    endtask

    initial begin
        // reset
        rst = 1; step(); step();
        chk("rst_count", int'(count), 0);
        chk("rst_at_max", int'(at_max), 0);

        // 60 ticks: full wrap with a single carry
        clear_in();
        carries = 0;
        tick = 1;
        for (int i = 0; i < 60; i++) begin
            if (i == 59) chk("pre_wrap_count", int'(count), 59);
            step();
        end
        tick = 0; step();
        chk("wrap_count", int'(count), 0);
        chk("wrap_carries", carries, 1);

        // load 58, two ticks
        carries = 0;
        load = 1; load_val = 6'd58; step();
        load = 0; tick = 1; step(); step();
        tick = 0; step();
        chk("load58_end", int'(count), 0);
        chk("load58_carries", carries, 1);

        // rejected loads 60 and 63
        load = 1; load_val = 6'd60; step();
        chk("rej60_err", int'(load_err), 1);
        load = 0; step();
        load = 1; load_val = 6'd63; step();
        chk("rej63_count", int'(count), 0);
        load = 0; step();

        // SET mode adjustments
        carries = 0;
        set_mode = 1; step();
        inc = 1; repeat (5) step();
        inc = 0; step();
        chk("set_inc_held", int'(count), 1);
        repeat (2) begin
            dec = 1; step(); dec = 0; step();
        end
        chk("set_dec_wrap", int'(count), 59);
        tick = 1; repeat (4) step(); tick = 0;
        chk("set_tick_ignored", int'(count), 59);
        chk("set_no_carry", carries, 0);

        // tick and set_mode rising together at 59
        set_mode = 0; step();
        load = 1; load_val = 6'd59; step(); load = 0;
        tick = 1; set_mode = 1; step(); tick = 0;
        chk("tick_set_count", int'(count), 0);
        chk("tick_set_carry", int'(carry), 1);
        chk("tick_set_inset", int'(in_set), 1);

        // reset with load while in SET at 30
        load = 1; load_val = 6'd30; step();
        rst = 1; load_val = 6'd10; step();
        chk("rst_load_count", int'(count), 0);
        chk("rst_load_inset", int'(in_set), 0);
        clear_in(); set_mode = 0;

        // button held through reset release
        inc = 1; rst = 1; step(); rst = 0; set_mode = 1; step(); step();
        chk("held_inc_no_rise", int'(count), 0);
        clear_in();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            tick     = ($urandom_range(0, 2) == 0);
            inc      = $urandom_range(0, 1);
            dec      = $urandom_range(0, 1);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 24) == 0) set_mode = ~set_mode;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sec_min_counter.md
SEC_MIN_COUNTER -- requirements
Module: sec_min_counter

Interface
REQ-001 The block SHALL have parameter MAX, default 59, meaning the terminal count; the count wraps MAX -> 0.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-004 The block SHALL have port tick, input, 1 bit, meaning a one-cycle count-enable pulse (1 Hz for seconds, upstream carry for minutes).
REQ-005 The block SHALL have port set_mode, input, 1 bit, meaning level select: 0 = RUN, 1 = SET.
REQ-006 The block SHALL have port inc, input, 1 bit, meaning the adjust-up button (already synchronized upstream); it acts on its rising edge only.
REQ-007 The block SHALL have port dec, input, 1 bit, meaning the adjust-down button (already synchronized upstream); it acts on its rising edge only.
REQ-008 The block SHALL have port load, input, 1 bit, meaning a one-cycle request to load load_val.
REQ-009 The block SHALL have port load_val, input, [0:5], meaning the preset value; index 0 is the MSB.
REQ-010 The block SHALL have port count, output, [0:5], meaning the registered current value; index 0 is the MSB.
REQ-011 The block SHALL have port carry, output, 1 bit, meaning a registered one-cycle pulse on a RUN-mode wrap.
REQ-012 The block SHALL have port at_max, output, 1 bit, meaning combinational count == MAX; it feeds the downstream 59-detect path.
REQ-013 The block SHALL have port load_err, output, 1 bit, meaning a registered one-cycle pulse when a load value is rejected.
REQ-014 The block SHALL have port in_set, output, 1 bit, meaning the registered state indicator: 1 = SET.

Function
REQ-015 The FSM SHALL have two states, RUN and SET; RUN -> SET and SET -> RUN SHALL each occur on the first edge at which the sampled set_mode differs from the current state.
REQ-016 Events in a cycle SHALL be evaluated against the state held before that edge; a tick coincident with the RUN -> SET change SHALL still count.
REQ-017 In RUN, with tick = 1 and count < MAX, count SHALL become count + 1 at the edge.
REQ-018 In RUN, with tick = 1 and count == MAX, count SHALL become 0 and carry SHALL be 1 for exactly the following cycle.
REQ-019 carry SHALL be 0 in every other cycle, including all cycles in SET and every inc/dec wrap.
REQ-020 In SET, tick SHALL be ignored.
REQ-021 The block SHALL derive inc_rise and dec_rise as (input && !input_delayed), using one flop per input.
REQ-022 In SET, inc_rise SHALL step count +1, with MAX wrapping to 0.
REQ-023 In SET, dec_rise SHALL step count -1, with 0 wrapping to MAX.
REQ-024 In SET, simultaneous inc_rise and dec_rise SHALL leave count unchanged.
REQ-025 In RUN, inc and dec SHALL be ignored, but their delay flops SHALL still update.
REQ-026 load = 1 with load_val <= MAX SHALL set count = load_val at the edge, in either state.
REQ-027 A valid load SHALL take priority over tick, inc_rise and dec_rise in that cycle and SHALL produce no carry.
REQ-028 load = 1 with load_val > MAX SHALL leave count unchanged and pulse load_err for one cycle.
REQ-029 In the cycle of a rejected load, the other events (tick, inc_rise, dec_rise) SHALL proceed normally.
REQ-030 Arithmetic SHALL be 6-bit unsigned, and count SHALL never hold a value > MAX.
REQ-031 The block SHALL have no other outputs or side effects.

Reset
REQ-032 rst SHALL be sampled only on the rising edge of clk and SHALL override all other inputs.
REQ-033 After a reset edge: count = 0, carry = 0, load_err = 0, in_set = 0 (state RUN), and both button delay flops = 0.
REQ-034 A reset asserted mid-SET or coincident with a wrap SHALL suppress that cycle's carry.
REQ-035 A reset coincident with a load SHALL ignore the load.
REQ-036 at_max SHALL read 0 after reset because count = 0.
REQ-037 A button held high through reset release SHALL not generate a rise event.

Verification
REQ-038 Reset, then 60 tick pulses in RUN -> count steps 0..59 then 0; carry is high for exactly one cycle, after the 60th tick; at_max = 1 only while count = 59.
REQ-039 load with load_val = 58, then 2 ticks -> count 58, 59, 0; carry pulses once.
REQ-040 load with load_val = 60 (111100) -> count unchanged and load_err pulses once; then load_val = 63 -> same behaviour.
REQ-041 set_mode = 1 at count = 0, inc held high for 5 cycles -> count = 1 only; dec pulsed twice -> count 0 then 59, with carry = 0 throughout; ticks in SET do not move count.
REQ-042 RUN at count = 59, with tick and set_mode rising in the same cycle -> count = 0, carry pulses, in_set = 1 on the next cycle.
REQ-043 In SET at count = 30, assert rst with load = 1 (load_val = 10) -> count = 0, in_set = 0, load_err = 0.
